pipeline_ctrl: RTL

Central hazard and sequencing controller for the five-stage MIPS pipeline. It issues per-stage stall and flush (bubble) commands and owns the fetch redirect path. It handles four events: load-use interlocks against the decode stage's `rs`/`rt` sources, multi-cycle divide occupancy of the execute stage, jumps resolved in decode whose delay slot has not yet been fetched, and exceptions committed at write-back. It sits beside the stage registers and drives their enable/clear inputs; forwarding stays inside decode.

---
 rtl/pipeline_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
`timescale 1ns/1ps
// pipeline_ctrl: hazard and sequencing controller for the five-stage pipeline.
// Issues per-stage stall/flush commands, tracks multi-cycle divides, holds a
// jump whose delay slot is still being fetched, and redirects fetch on
// exceptions and jumps. All command outputs are combinational.
module pipeline_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_busy,
  input  logic        d_valid,
  input  logic        d_uses_rs,
  input  logic        d_uses_rt,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_jmp_valid,
  input  logic        d_jmp_delayed,
  input  logic [31:0] d_jmp_pc,
  input  logic        e_valid,
  input  logic        e_is_load,
  input  logic [4:0]  e_dst,
  input  logic        e_div_start,
  input  logic        m_busy,
  input  logic        w_exc_valid,
  input  logic [31:0] w_exc_pc,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_m,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        div_done
);

  typedef enum logic [1:0] {
    RUN = 2'd0,
    DIV = 2'd1,
    EXC = 2'd2
  } state_t;

  // The start cycle counts as the first stall cycle and the counter reaches
  // zero on the last one, so it is loaded two short of the full occupancy.
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  div_cnt_reg, div_cnt_next;
  logic              pend_jmp_reg, pend_jmp_next;
  logic [31:0]       pend_pc_reg, pend_pc_next;
  logic              load_use;

  // A load in execute feeding a source that decode actually reads; $0 never
  // creates a dependency.
  assign load_use = e_valid & e_is_load & (e_dst != 5'd0) & d_valid &
                    ((d_uses_rs & (d_rs == e_dst)) | (d_uses_rt & (d_rt == e_dst)));

  // State, divide counter and pending-jump registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= RUN;
      div_cnt_reg  <= '0;
      pend_jmp_reg <= 1'b0;
      pend_pc_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      pend_jmp_reg <= pend_jmp_next;
      pend_pc_reg  <= pend_pc_next;
    end
  end

  // Prioritised event decode: exception, memory wait, divide, load-use,
  // fetch wait, then jump handling.
  always_comb begin
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    stall_e        = 1'b0;
    stall_m        = 1'b0;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    flush_m        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    div_done       = 1'b0;
    state_next     = state_reg;
    div_cnt_next   = div_cnt_reg;
    pend_jmp_next  = pend_jmp_reg;
    pend_pc_next   = pend_pc_reg;

    if (w_exc_valid) begin
      // Kill everything younger than write-back and abort any divide.
      flush_d        = 1'b1;
      flush_e        = 1'b1;
      flush_m        = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = w_exc_pc;
      state_next     = EXC;
      div_cnt_next   = '0;
      pend_jmp_next  = 1'b0;
    end else if (m_busy) begin
      // Whole pipe waits on the data bus; nothing advances.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
    end else begin
      case (state_reg)
        EXC: begin
          // Drop the instruction fetched on the wrong path before the redirect.
          flush_d    = 1'b1;
          state_next = RUN;
        end
        DIV: begin
          // Execute stays occupied through the final cycle that delivers the result.
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          if (div_cnt_reg == '0) begin
            div_done   = 1'b1;
            state_next = RUN;
          end else begin
            div_cnt_next = div_cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          if (e_div_start) begin
            stall_f      = 1'b1;
            stall_d      = 1'b1;
            stall_e      = 1'b1;
            flush_m      = 1'b1;
            state_next   = DIV;
            div_cnt_next = DIV_LOAD;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end else if (f_busy) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
          end

          // While a jump is pending its delay slot occupies decode, so no new
          // jump can be seen; release the pending target once fetch can move.
          if (pend_jmp_reg) begin
            if (!stall_f) begin
              redirect_valid = 1'b1;
              redirect_pc    = pend_pc_reg;
              pend_jmp_next  = 1'b0;
            end
          end else if (d_jmp_valid && !stall_d) begin
            if (d_jmp_delayed) begin
              pend_jmp_next = 1'b1;
              pend_pc_next  = d_jmp_pc;
            end else begin
              redirect_valid = 1'b1;
              redirect_pc    = d_jmp_pc;
            end
          end
        end
      endcase
    end
  end

endmodule
